// File: rtl/enum_arb_pkg.sv
// Shared types for the round-robin arbiter: FSM states, requester ids and
// the id-to-grant decode.
package enum_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} arb_state_t;
    typedef enum logic [1:0] {ID0, ID1, ID2, ID3} req_id_t;

    function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
        return NREQ'(1) << id;
    endfunction

endpackage

// File: rtl/enum_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr, wrapping ID3 -> ID0.
module enum_rr_pick
    import enum_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic            valid,
    output req_id_t         id
);

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        valid = |req;
        id    = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[2'(ptr + 2'(i))]) id = req_id_t'(2'(ptr + 2'(i)));
        end
    end

endmodule

// File: rtl/enum_rr_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant, optional hold
// limit and a mandatory dead cycle between owners.
module enum_rr_arbiter
    import enum_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter req_id_t     START_ID = ID0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output req_id_t         gnt_id,
    output logic            busy,
    output arb_state_t      state_o
);

    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    arb_state_t    state, state_nxt;
    req_id_t       ptr, owner, pick_id;
    logic [HW-1:0] hold_cnt;
    logic          pick_valid;
    logic          rel;

    enum_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // A dropped request and an expired hold budget collapse into one release.
    assign rel = !req[owner] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_GAP: state_nxt = pick_valid ? S_GRANT : S_IDLE;
            S_GRANT:       if (rel) state_nxt = S_GAP;
            default: begin
                state_nxt = S_IDLE;
                assert (1'b0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt      <= '0;
            owner    <= START_ID;
            ptr      <= START_ID;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    if (pick_valid) begin
                        owner    <= pick_id;
                        hold_cnt <= '0;
                        gnt      <= id_onehot(pick_id);
                    end
                end
                S_GRANT: begin
                    if (rel) begin
                        gnt <= '0;
                        ptr <= req_id_t'(2'(owner + 2'd1));
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    gnt <= '0;
                    assert (1'b0);
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state == S_GRANT);
        gnt_id  = owner;
        state_o = state;
    end

    always @(*) begin
        assert (state != 2'h3);
        assert ($onehot0(gnt));
        assert ((gnt != '0) == (state == S_GRANT));
        assert (busy == (state == S_GRANT));
        if (state == S_GRANT) assert (gnt == id_onehot(owner));
    end

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Bench for enum_rr_arbiter: directed scenarios plus random traffic, with a
// queue-free round-robin model checking two instances (MAX_HOLD 8 and 0).
module tb_enum_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'h0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b, st_a, st_b;
    logic       busy_a, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enum_rr_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .state_o(st_a)
    );

    enum_rr_arbiter #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .state_o(st_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: held = number of grant cycles the current owner has had (0 = none).
    int mhold[2] = '{8, 0};
    int m_held[2], m_owner[2], m_ptr[2], m_last[2];
    bit m_gap[2];
    bit m_valid = 0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_held[d] = 0;
                m_ptr[d]  = 0;
                m_last[d] = 0;
                m_gap[d]  = 0;
            end else if (m_held[d] > 0) begin
                if (!req[m_owner[d]] || (mhold[d] != 0 && m_held[d] == mhold[d])) begin
                    m_held[d] = 0;
                    m_ptr[d]  = (m_owner[d] + 1) % 4;
                    m_gap[d]  = 1;
                end else begin
                    m_held[d]++;
                end
            end else begin
                m_gap[d] = 0;
                for (int k = 3; k >= 0; k--) begin
                    if (req[(m_ptr[d] + k) % 4]) m_owner[d] = (m_ptr[d] + k) % 4;
                end
                if (req != 4'h0) begin
                    m_held[d] = 1;
                    m_last[d] = m_owner[d];
                end
            end
        end
        if (!rst) m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                int eg, es;
                eg = (m_held[d] > 0) ? (1 << m_owner[d]) : 0;
                es = (m_held[d] > 0) ? 1 : (m_gap[d] ? 2 : 0);
                chk(d ? "b.gnt" : "a.gnt", int'(d ? gnt_b : gnt_a), eg);
                chk(d ? "b.gnt_id" : "a.gnt_id", int'(d ? id_b : id_a), m_last[d]);
                chk(d ? "b.busy" : "a.busy", int'(d ? busy_b : busy_a), int'(m_held[d] > 0));
                chk(d ? "b.state" : "a.state", int'(d ? st_b : st_a), es);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with all requests pending
        rst = 1'b0; req = 4'hF;
        cyc(2);
        chk("rst.gnt", int'(gnt_a), 0);
        chk("rst.busy", int'(busy_a), 0);
        chk("rst.state", int'(st_a), 0);
        chk("rst.gnt_id", int'(id_a), 0);
        rst = 1'b1;
        cyc(1);
        chk("first.gnt", int'(gnt_a), 4'b0001);
        req = 4'h0;
        cyc(2);

        // Single requester, then release into gap and idle
        req = 4'b0100;
        cyc(1);
        chk("t2.gnt", int'(gnt_a), 4'b0100);
        chk("t2.gnt_id", int'(id_a), 2);
        cyc(2);
        req = 4'h0;
        cyc(1);
        chk("t2.gap.gnt", int'(gnt_a), 0);
        chk("t2.gap.state", int'(st_a), 2);
        cyc(1);
        chk("t2.idle.state", int'(st_a), 0);
        chk("t2.idle.gnt_id", int'(id_a), 2);

        // Pointer at ID3 must wrap to ID0 ahead of ID1
        req = 4'b0011;
        cyc(1);
        chk("wrap.gnt", int'(gnt_a), 4'b0001);
        chk("wrap.gnt_id", int'(id_a), 0);
        req = 4'h0;
        cyc(2);

        // Reset mid-grant
        req = 4'b0010;
        cyc(1);
        chk("t5.gnt", int'(gnt_a), 4'b0010);
        rst = 1'b0;
        cyc(1);
        chk("t5.rst.gnt", int'(gnt_a), 0);
        chk("t5.rst.state", int'(st_a), 0);
        rst = 1'b1; req = 4'hF;
        cyc(1);
        chk("t5.after.gnt", int'(gnt_a), 4'b0001);

        // Hold limit with everybody requesting
        cyc(7);
        chk("t3.c8.gnt", int'(gnt_a), 4'b0001);
        cyc(1);
        chk("t3.c9.gnt", int'(gnt_a), 0);
        cyc(1);
        chk("t3.c10.gnt", int'(gnt_a), 4'b0010);
        cyc(7);
        chk("t3.c17.gnt", int'(gnt_a), 4'b0010);
        cyc(1);
        chk("t3.c18.gnt", int'(gnt_a), 0);
        cyc(1);
        chk("t3.c19.gnt", int'(gnt_a), 4'b0100);
        req = 4'h0;
        cyc(2);

        // Unlimited hold never preempts
        req = 4'b0001;
        cyc(1);
        for (int i = 0; i < 100; i++) begin
            chk("t6.gnt", int'(gnt_b), 4'b0001);
            cyc(1);
        end
        req = 4'h0;
        cyc(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            cyc(1);
        end
        rst = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
